// File: rtl/wb_dcache_evict_buffer.sv
// Eviction buffer for the write-back dcache: queues dirty victim lines and
// drains them to AXI AW/W/B, with an address lookup over in-flight lines.
module wb_dcache_evict_buffer #(
    parameter int unsigned NrEntries    = 2,
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiId        = 1,
    parameter bit          BurstEn      = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        evict_valid_i,
    output logic                        evict_ready_o,
    input  logic [AxiAddrWidth-1:0]     evict_addr_i,
    input  logic [LineWidth-1:0]        evict_data_i,
    input  logic [AxiAddrWidth-1:0]     lookup_addr_i,
    output logic                        lookup_hit_o,
    output logic                        empty_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AxiAddrWidth-1:0]     aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [AxiIdWidth-1:0]       aw_id_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AxiDataWidth-1:0]     w_data_o,
    output logic [AxiDataWidth/8-1:0]   w_strb_o,
    output logic                        w_last_o,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    output logic                        err_o
);

    localparam int unsigned Beats = LineWidth / AxiDataWidth;
    localparam int unsigned OffW  = $clog2(LineWidth / 8);
    localparam int unsigned PtrW  = $clog2(NrEntries);
    localparam int unsigned CntW  = $clog2(NrEntries + 1);
    localparam int unsigned BcntW = $clog2(Beats + 1);
    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam logic [AxiAddrWidth-1:0] OffMask = AxiAddrWidth'((1 << OffW) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_RESP
    } state_e;

    state_e                             state_q, state_d;
    logic [PtrW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                    count_q, count_d;
    logic [BcntW-1:0]                   bcnt_q, bcnt_d;
    logic                               err_q, err_d;
    logic [AxiAddrWidth-1:0]            addr_q [NrEntries];
    logic [Beats-1:0][AxiDataWidth-1:0] data_q [NrEntries];

    logic                               push, pop;
    logic                               last_beat, last_word_done;
    logic [AxiAddrWidth-1:0]            head_addr, word_off;
    logic [AxiDataWidth-1:0]            cur_word;
    logic [NrEntries-1:0]               slot_hit;
    logic                               unused_bits;

    assign unused_bits   = ^{b_resp_i[0], lookup_addr_i[OffW-1:0]};

    assign evict_ready_o = (count_q != CntW'(NrEntries));
    assign empty_o       = (count_q == '0);
    assign push          = evict_valid_i & evict_ready_o;
    assign err_o         = err_q;
    assign aw_id_o       = AxiIdWidth'(AxiId);
    assign w_strb_o      = '1;

    assign head_addr      = addr_q[rd_ptr_q];
    assign word_off       = BurstEn ? '0 : AxiAddrWidth'(bcnt_q) * AxiAddrWidth'(StrbW);
    assign last_beat      = BurstEn ? (bcnt_q == BcntW'(Beats - 1)) : 1'b1;
    // bcnt reaches Beats once every word of the head line has been written
    assign last_word_done = (bcnt_q == BcntW'(Beats));

    always_comb begin
        cur_word = '0;
        for (int unsigned b = 0; b < Beats; b++) begin
            if (bcnt_q == BcntW'(b)) cur_word = data_q[rd_ptr_q][b];
        end
    end

    for (genvar g = 0; g < NrEntries; g++) begin : g_slot
        logic [PtrW-1:0] rel;
        assign rel         = PtrW'(g) - rd_ptr_q;
        assign slot_hit[g] = (CntW'(rel) < count_q) &&
                             (addr_q[g][AxiAddrWidth-1:OffW] == lookup_addr_i[AxiAddrWidth-1:OffW]);
    end
    assign lookup_hit_o = |slot_hit;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        err_d      = 1'b0;
        pop        = 1'b0;
        aw_valid_o = 1'b0;
        aw_addr_o  = '0;
        aw_len_o   = '0;
        w_valid_o  = 1'b0;
        w_data_o   = '0;
        w_last_o   = 1'b0;
        b_ready_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_AW;
            end
            S_AW: begin
                aw_valid_o = 1'b1;
                aw_addr_o  = head_addr + word_off;
                aw_len_o   = BurstEn ? 8'(Beats - 1) : 8'd0;
                if (aw_ready_i) state_d = S_W;
            end
            S_W: begin
                w_valid_o = 1'b1;
                w_data_o  = cur_word;
                w_last_o  = last_beat;
                if (w_ready_i) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (last_beat) state_d = S_RESP;
                end
            end
            S_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    err_d = b_resp_i[1];
                    if (last_word_done) begin
                        pop     = 1'b1;
                        bcnt_d  = '0;
                        state_d = (count_q > CntW'(1)) ? S_AW : S_IDLE;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bcnt_q   <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NrEntries; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bcnt_q   <= bcnt_d;
            err_q    <= err_d;
            if (push) begin
                addr_q[wr_ptr_q] <= evict_addr_i & ~OffMask;
                data_q[wr_ptr_q] <= evict_data_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_dcache_evict_buffer.sv
// Directed bench: instance u0 drains one single-beat transaction per word,
// instance u1 drains one INCR burst per line.
module tb_wb_dcache_evict_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  lookup_addr = '0;

    logic         ev_valid0 = 1'b0, ev_ready0;
    logic [63:0]  ev_addr0 = '0;
    logic [127:0] ev_data0 = '0;
    logic         hit0, empty0;
    logic         aw_valid0, aw_ready0 = 1'b0;
    logic [63:0]  aw_addr0;
    logic [7:0]   aw_len0;
    logic [3:0]   aw_id0;
    logic         w_valid0, w_ready0 = 1'b0, w_last0;
    logic [63:0]  w_data0;
    logic [7:0]   w_strb0;
    logic         b_valid0 = 1'b0, b_ready0, err0;
    logic [1:0]   b_resp0 = 2'b00;

    logic         ev_valid1 = 1'b0, ev_ready1;
    logic [63:0]  ev_addr1 = '0;
    logic [127:0] ev_data1 = '0;
    logic         hit1, empty1;
    logic         aw_valid1, aw_ready1 = 1'b1;
    logic [63:0]  aw_addr1;
    logic [7:0]   aw_len1;
    logic [3:0]   aw_id1;
    logic         w_valid1, w_ready1 = 1'b1, w_last1;
    logic [63:0]  w_data1;
    logic [7:0]   w_strb1;
    logic         b_valid1 = 1'b1, b_ready1, err1;
    logic [1:0]   b_resp1 = 2'b00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_dcache_evict_buffer #(
        .NrEntries(2), .LineWidth(128), .AxiDataWidth(64), .AxiAddrWidth(64),
        .AxiIdWidth(4), .AxiId(1), .BurstEn(1'b0)
    ) u0 (
        .clk_i(clk), .rst_i(rst),
        .evict_valid_i(ev_valid0), .evict_ready_o(ev_ready0),
        .evict_addr_i(ev_addr0), .evict_data_i(ev_data0),
        .lookup_addr_i(lookup_addr), .lookup_hit_o(hit0), .empty_o(empty0),
        .aw_valid_o(aw_valid0), .aw_ready_i(aw_ready0), .aw_addr_o(aw_addr0),
        .aw_len_o(aw_len0), .aw_id_o(aw_id0),
        .w_valid_o(w_valid0), .w_ready_i(w_ready0), .w_data_o(w_data0),
        .w_strb_o(w_strb0), .w_last_o(w_last0),
        .b_valid_i(b_valid0), .b_ready_o(b_ready0), .b_resp_i(b_resp0), .err_o(err0)
    );

    wb_dcache_evict_buffer #(
        .NrEntries(2), .LineWidth(128), .AxiDataWidth(64), .AxiAddrWidth(64),
        .AxiIdWidth(4), .AxiId(1), .BurstEn(1'b1)
    ) u1 (
        .clk_i(clk), .rst_i(rst),
        .evict_valid_i(ev_valid1), .evict_ready_o(ev_ready1),
        .evict_addr_i(ev_addr1), .evict_data_i(ev_data1),
        .lookup_addr_i(lookup_addr), .lookup_hit_o(hit1), .empty_o(empty1),
        .aw_valid_o(aw_valid1), .aw_ready_i(aw_ready1), .aw_addr_o(aw_addr1),
        .aw_len_o(aw_len1), .aw_id_o(aw_id1),
        .w_valid_o(w_valid1), .w_ready_i(w_ready1), .w_data_o(w_data1),
        .w_strb_o(w_strb1), .w_last_o(w_last1),
        .b_valid_i(b_valid1), .b_ready_o(b_ready1), .b_resp_i(b_resp1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    // One single-beat word on u0: AW, W, then B with the given response.
    // The first sampled cycle also carries the err pulse from the previous B.
    task automatic drain_word(input string tag, input logic [63:0] a, input logic [63:0] d,
                              input logic [1:0] resp, input logic exp_err, input logic exp_rdy);
        nstep();
        chk({tag, " err_prev"}, err0, exp_err);
        chk({tag, " evict_ready"}, ev_ready0, exp_rdy);
        b_resp0 = 2'b00;
        for (int n = 0; n < 10 && !aw_valid0; n++) nstep();
        chk({tag, " aw_valid"}, aw_valid0, 1'b1);
        chk({tag, " aw_addr"}, aw_addr0, a);
        aw_ready0 = 1'b1;
        nstep();
        chk({tag, " w_data"}, w_data0, d);
        chk({tag, " w_last"}, w_last0, 1'b1);
        chk({tag, " err_clear"}, err0, 1'b0);
        nstep();
        chk({tag, " b_ready"}, b_ready0, 1'b1);
        b_resp0 = resp;
    endtask

    initial begin
        // reset state
        nstep();
        nstep();
        chk("rst evict_ready", ev_ready0, 1'b1);
        chk("rst empty", empty0, 1'b1);
        chk("rst lookup_hit", hit0, 1'b0);
        chk("rst aw_valid", aw_valid0, 1'b0);
        chk("rst w_valid", w_valid0, 1'b0);
        chk("rst b_ready", b_ready0, 1'b0);
        chk("rst err", err0, 1'b0);
        chk("rst aw_addr", aw_addr0, 64'h0);
        chk("rst w_data", w_data0, 64'h0);
        chk("rst u1 empty", empty1, 1'b1);

        // T1 / T4: single-beat drain with lookup
        nstep();
        rst = 1'b0;
        aw_ready0 = 1'b1; w_ready0 = 1'b1; b_valid0 = 1'b1;
        ev_valid0 = 1'b1; ev_addr0 = 64'h8000_0010; ev_data0 = {64'hB, 64'hA};
        lookup_addr = 64'h8000_001C;
        #1;
        chk("T1 evict_ready", ev_ready0, 1'b1);
        chk("T4 hit same-cycle push", hit0, 1'b0);
        nstep(); ev_valid0 = 1'b0;
        chk("T1 empty after push", empty0, 1'b0);
        chk("T1 aw_valid t+1", aw_valid0, 1'b0);
        chk("T4 hit queued", hit0, 1'b1);
        nstep();
        chk("T1 aw0 valid t+2", aw_valid0, 1'b1);
        chk("T1 aw0 addr", aw_addr0, 64'h8000_0010);
        chk("T1 aw0 len", aw_len0, 8'd0);
        chk("T1 aw0 id", aw_id0, 4'd1);
        nstep();
        chk("T1 aw0 dropped", aw_valid0, 1'b0);
        chk("T1 w0 valid", w_valid0, 1'b1);
        chk("T1 w0 data", w_data0, 64'hA);
        chk("T1 w0 last", w_last0, 1'b1);
        chk("T1 w0 strb", w_strb0, 8'hFF);
        nstep();
        chk("T1 b0 ready", b_ready0, 1'b1);
        chk("T1 w0 dropped", w_valid0, 1'b0);
        nstep();
        chk("T1 aw1 valid", aw_valid0, 1'b1);
        chk("T1 aw1 addr", aw_addr0, 64'h8000_0018);
        nstep();
        chk("T1 w1 data", w_data0, 64'hB);
        chk("T1 w1 last", w_last0, 1'b1);
        nstep();
        chk("T1 b1 ready", b_ready0, 1'b1);
        chk("T4 hit awaiting B", hit0, 1'b1);
        chk("T1 not empty before B", empty0, 1'b0);
        nstep();
        chk("T1 empty after B", empty0, 1'b1);
        chk("T4 hit after B", hit0, 1'b0);
        chk("T1 b idle", b_ready0, 1'b0);
        chk("T1 aw idle", aw_valid0, 1'b0);

        // T2: burst drain on u1
        ev_valid1 = 1'b1; ev_addr1 = 64'h8000_0010; ev_data1 = {64'hB, 64'hA};
        #1;
        chk("T2 evict_ready", ev_ready1, 1'b1);
        nstep(); ev_valid1 = 1'b0;
        chk("T2 aw_valid t+1", aw_valid1, 1'b0);
        nstep();
        chk("T2 aw valid", aw_valid1, 1'b1);
        chk("T2 aw addr", aw_addr1, 64'h8000_0010);
        chk("T2 aw len", aw_len1, 8'd1);
        nstep();
        chk("T2 w0 data", w_data1, 64'hA);
        chk("T2 w0 last", w_last1, 1'b0);
        nstep();
        chk("T2 w1 data", w_data1, 64'hB);
        chk("T2 w1 last", w_last1, 1'b1);
        chk("T2 single aw", aw_valid1, 1'b0);
        nstep();
        chk("T2 b ready", b_ready1, 1'b1);
        chk("T2 not empty", empty1, 1'b0);
        nstep();
        chk("T2 empty after B", empty1, 1'b1);
        chk("T2 b idle", b_ready1, 1'b0);
        chk("T2 no second aw", aw_valid1, 1'b0);

        // T3: fill both slots with AW stalled; second push wraps wr_ptr
        aw_ready0 = 1'b0;
        ev_valid0 = 1'b1; ev_addr0 = 64'h8000_0040;
        ev_data0 = {64'h1111_0000_0000_0041, 64'h1111_0000_0000_0040};
        #1;
        chk("T3 ready push X", ev_ready0, 1'b1);
        nstep();
        ev_addr0 = 64'h8000_0085;
        ev_data0 = {64'h2222_0000_0000_0081, 64'h2222_0000_0000_0080};
        chk("T3 ready push Y", ev_ready0, 1'b1);
        nstep();
        ev_addr0 = 64'h8000_00C0; ev_data0 = {64'h3, 64'h3};
        chk("T3 full", ev_ready0, 1'b0);
        chk("T3 aw X stalled", aw_addr0, 64'h8000_0040);
        nstep();
        chk("T3 third held", ev_ready0, 1'b0);
        chk("T3 aw still valid", aw_valid0, 1'b1);
        chk("T3 aw stable", aw_addr0, 64'h8000_0040);
        lookup_addr = 64'h8000_0088;
        #1;
        chk("T3 hit Y", hit0, 1'b1);
        lookup_addr = 64'h8000_00C0;
        #1;
        chk("T3 miss held Z", hit0, 1'b0);
        ev_valid0 = 1'b0;

        // T3 drain order X then Y; T5 error on X's final B
        drain_word("T3 X0", 64'h8000_0040, 64'h1111_0000_0000_0040, 2'b00, 1'b0, 1'b0);
        drain_word("T5 X1", 64'h8000_0048, 64'h1111_0000_0000_0041, 2'b10, 1'b0, 1'b0);
        drain_word("T5 Y0", 64'h8000_0080, 64'h2222_0000_0000_0080, 2'b00, 1'b1, 1'b1);
        drain_word("T3 Y1", 64'h8000_0088, 64'h2222_0000_0000_0081, 2'b00, 1'b0, 1'b1);
        nstep();
        b_resp0 = 2'b00;
        chk("T3 err quiet", err0, 1'b0);
        chk("T3 empty", empty0, 1'b1);

        // T6: asynchronous reset while stuck in W with both slots full
        w_ready0 = 1'b0;
        ev_valid0 = 1'b1; ev_addr0 = 64'h8000_0100; ev_data0 = {64'h5, 64'h4};
        nstep();
        ev_addr0 = 64'h8000_0200; ev_data0 = {64'h7, 64'h6};
        nstep();
        ev_valid0 = 1'b0;
        lookup_addr = 64'h8000_0100;
        #1;
        chk("T6 full", ev_ready0, 1'b0);
        nstep();
        chk("T6 in W", w_valid0, 1'b1);
        chk("T6 hit before rst", hit0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("T6 aw_valid", aw_valid0, 1'b0);
        chk("T6 w_valid", w_valid0, 1'b0);
        chk("T6 b_ready", b_ready0, 1'b0);
        chk("T6 w_data", w_data0, 64'h0);
        chk("T6 lookup_hit", hit0, 1'b0);
        nstep();
        rst = 1'b0;
        #1;
        chk("T6 empty after release", empty0, 1'b1);
        chk("T6 evict_ready after release", ev_ready0, 1'b1);
        chk("T6 w idle after release", w_valid0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
